// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types and sizing: dispatch/retire packet, index/tag type and width constants.
`ifndef ROB_SZ
`define ROB_SZ 32
`endif
`ifndef N
`define N 3
`endif

package reorder_buffer_pkg;

    localparam int unsigned NUM_SCALAR_BITS = $clog2(`N + 1);
    localparam int unsigned ROB_IDX_BITS    = $clog2(`ROB_SZ);

    typedef logic [ROB_IDX_BITS-1:0] ROB_IDX;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  dest_reg;
        logic        has_dest;
    } ROB_PACKET;

endpackage

// File: rtl/rob_wrap_add.sv
// Combinational (idx + off) mod ROB_SZ using compare/subtract, valid for any ROB_SZ >= off.
module rob_wrap_add #(
    parameter int unsigned ROB_SZ = 32,
    parameter int unsigned OFF_W  = 2,
    localparam int unsigned IDX_W = $clog2(ROB_SZ),
    localparam int unsigned SUM_W = IDX_W + OFF_W
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [OFF_W-1:0] off,
    output logic [IDX_W-1:0] sum_c
);

    logic [SUM_W-1:0] raw;

    always_comb begin
        raw   = SUM_W'(idx) + SUM_W'(off);
        sum_c = IDX_W'(raw);
        if (raw >= SUM_W'(ROB_SZ)) begin
            sum_c = IDX_W'(raw - SUM_W'(ROB_SZ));
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// N-wide circular reorder buffer between dispatch and retire, with full flush.
// Optional ROB_DEBUG_EN: adds debug_count port and illegal-input / occupancy checks.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_SZ = `ROB_SZ,
    parameter int unsigned N      = `N,
    localparam int unsigned IDX_W    = $clog2(ROB_SZ),
    localparam int unsigned CNT_W    = $clog2(ROB_SZ + 1),
    localparam int unsigned SCALAR_W = $clog2(N + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  ROB_PACKET           rob_inputs [N],
    input  logic [SCALAR_W-1:0] num_dispatched,
    output logic [SCALAR_W-1:0] rob_spots,
    output logic [IDX_W-1:0]    rob_tail,
    output ROB_PACKET           rob_outputs [N],
    output logic [SCALAR_W-1:0] rob_outputs_valid,
    input  logic [SCALAR_W-1:0] num_retiring
`ifdef ROB_DEBUG_EN
    ,
    output logic [CNT_W-1:0]    debug_count
`endif
);

    ROB_PACKET        entries [ROB_SZ];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] head_next;
    logic [IDX_W-1:0] tail_next;
    logic [IDX_W-1:0] wr_idx [N];
    logic [IDX_W-1:0] rd_idx [N];
    logic [CNT_W-1:0] free_c;

    rob_wrap_add #(.ROB_SZ(ROB_SZ), .OFF_W(SCALAR_W)) u_head_add (
        .idx(head), .off(num_retiring), .sum_c(head_next)
    );
    rob_wrap_add #(.ROB_SZ(ROB_SZ), .OFF_W(SCALAR_W)) u_tail_add (
        .idx(tail), .off(num_dispatched), .sum_c(tail_next)
    );

    // Per-slot write (from tail) and read (from head) indices.
    for (genvar g = 0; g < N; g++) begin : g_slot
        rob_wrap_add #(.ROB_SZ(ROB_SZ), .OFF_W(SCALAR_W)) u_wr_add (
            .idx(tail), .off(SCALAR_W'(g)), .sum_c(wr_idx[g])
        );
        rob_wrap_add #(.ROB_SZ(ROB_SZ), .OFF_W(SCALAR_W)) u_rd_add (
            .idx(head), .off(SCALAR_W'(g)), .sum_c(rd_idx[g])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_SZ; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            // Entry contents are left stale; count==0 hides them.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (SCALAR_W'(i) < num_dispatched) begin
                    entries[wr_idx[i]] <= rob_inputs[i];
                end
            end
            head  <= head_next;
            tail  <= tail_next;
            count <= count + CNT_W'(num_dispatched) - CNT_W'(num_retiring);
        end
    end

    // Outputs depend on registered state only; no same-cycle bypass.
    always_comb begin
        free_c            = CNT_W'(ROB_SZ) - count;
        rob_tail          = tail;
        rob_spots         = SCALAR_W'(N);
        rob_outputs_valid = SCALAR_W'(N);
        if (free_c < CNT_W'(N)) begin
            rob_spots = SCALAR_W'(free_c);
        end
        if (count < CNT_W'(N)) begin
            rob_outputs_valid = SCALAR_W'(count);
        end
        for (int i = 0; i < N; i++) begin
            rob_outputs[i] = entries[rd_idx[i]];
        end
    end

`ifdef ROB_DEBUG_EN
    logic [CNT_W-1:0] occ_c;

    assign debug_count = count;

    always_comb begin
        occ_c = CNT_W'(tail) - CNT_W'(head);
        if (tail < head) begin
            occ_c = CNT_W'(ROB_SZ) - CNT_W'(head) + CNT_W'(tail);
        end
    end

    always @(posedge clock) begin
        if (reset && !flush) begin
            assert (num_dispatched <= rob_spots) else $error("rob: dispatch exceeds rob_spots");
            assert (num_retiring <= rob_outputs_valid) else $error("rob: retire exceeds valid outputs");
            assert (num_dispatched <= SCALAR_W'(N)) else $error("rob: num_dispatched > N");
            assert (num_retiring <= SCALAR_W'(N)) else $error("rob: num_retiring > N");
        end
        if (reset) begin
            assert ((count == occ_c) || (count == CNT_W'(ROB_SZ) && occ_c == '0))
                else $error("rob: count inconsistent with head/tail");
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed + constrained-random bench for reorder_buffer at ROB_SZ=8, N=3.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int unsigned SZ = 8;
    localparam int unsigned W  = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    ROB_PACKET  rob_inputs [W];
    logic [1:0] num_dispatched;
    logic [1:0] rob_spots;
    logic [2:0] rob_tail;
    ROB_PACKET  rob_outputs [W];
    logic [1:0] rob_outputs_valid;
    logic [1:0] num_retiring;
`ifdef ROB_DEBUG_EN
    logic [3:0] debug_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int seq      = 0;
    int mtail    = 0;
    ROB_PACKET q [$];

    reorder_buffer #(.ROB_SZ(SZ), .N(W)) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .rob_inputs        (rob_inputs),
        .num_dispatched    (num_dispatched),
        .rob_spots         (rob_spots),
        .rob_tail          (rob_tail),
        .rob_outputs       (rob_outputs),
        .rob_outputs_valid (rob_outputs_valid),
        .num_retiring      (num_retiring)
`ifdef ROB_DEBUG_EN
        ,
        .debug_count       (debug_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic ROB_PACKET mk_pkt(input int k);
        ROB_PACKET p;
        p.pc       = 32'h1000 + 32'(k) * 4;
        p.dest_reg = 6'(k);
        p.has_dest = k[0];
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then advance the queue model to match.
    task automatic drive(input int nd, input int nr, input logic rst, input logic fl);
        reset          = rst;
        flush          = fl;
        num_dispatched = 2'(nd);
        num_retiring   = 2'(nr);
        for (int i = 0; i < W; i++) rob_inputs[i] = mk_pkt(seq + i);
        @(posedge clock);
        #1;
        if (!rst || fl) begin
            q.delete();
            mtail = 0;
        end else begin
            for (int r = 0; r < nr; r++) void'(q.pop_front());
            for (int i = 0; i < nd; i++) q.push_back(mk_pkt(seq + i));
            mtail = (mtail + nd) % SZ;
        end
        seq += W;
    endtask

    task automatic check_model(input string tag);
        int ev;
        int es;
        ev = (q.size() < W) ? q.size() : W;
        es = ((SZ - q.size()) < W) ? (SZ - q.size()) : W;
        check({tag, "_valid"}, 64'(rob_outputs_valid), 64'(ev));
        check({tag, "_spots"}, 64'(rob_spots), 64'(es));
        check({tag, "_tail"}, 64'(rob_tail), 64'(mtail));
        for (int i = 0; i < ev; i++) begin
            check($sformatf("%s_out%0d", tag, i), 64'(rob_outputs[i]), 64'(q[i]));
        end
    endtask

    initial begin
        int nd;
        int nr;
        int mv;
        int ms;

        reset = 1'b0; flush = 1'b0; num_dispatched = '0; num_retiring = '0;
        for (int i = 0; i < W; i++) rob_inputs[i] = '0;

        // Reset held two cycles
        drive(0, 0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b0);
        check("rst_valid", 64'(rob_outputs_valid), 64'd0);
        check("rst_spots", 64'(rob_spots), 64'd3);
        check("rst_tail", 64'(rob_tail), 64'd0);
        for (int i = 0; i < W; i++) check($sformatf("rst_out%0d", i), 64'(rob_outputs[i]), 64'd0);

        // First dispatch of packets 6,7,8
        drive(3, 0, 1'b1, 1'b0);
        check("d1_valid", 64'(rob_outputs_valid), 64'd3);
        check("d1_tail", 64'(rob_tail), 64'd3);
        check("d1_spots", 64'(rob_spots), 64'd3);
        for (int i = 0; i < W; i++) check($sformatf("d1_out%0d", i), 64'(rob_outputs[i]), 64'(mk_pkt(6 + i)));

        // Reset wins over flush and dispatch mid-operation
        drive(3, 0, 1'b0, 1'b1);
        check("mrst_valid", 64'(rob_outputs_valid), 64'd0);
        check("mrst_tail", 64'(rob_tail), 64'd0);
        check("mrst_spots", 64'(rob_spots), 64'd3);

        // Fill: 3,3,2
        drive(3, 0, 1'b1, 1'b0);
        check("fill1_spots", 64'(rob_spots), 64'd3);
        check("fill1_tail", 64'(rob_tail), 64'd3);
        drive(3, 0, 1'b1, 1'b0);
        check("fill2_spots", 64'(rob_spots), 64'd2);
        check("fill2_tail", 64'(rob_tail), 64'd6);
        drive(2, 0, 1'b1, 1'b0);
        check("full_spots", 64'(rob_spots), 64'd0);
        check("full_valid", 64'(rob_outputs_valid), 64'd3);
        check("full_tail", 64'(rob_tail), 64'd0);
        check_model("full");
        drive(0, 0, 1'b1, 1'b0);
        check("hold_spots", 64'(rob_spots), 64'd0);
        check("hold_valid", 64'(rob_outputs_valid), 64'd3);

        // Retire 2 while full: spots rise only afterwards
        drive(0, 2, 1'b1, 1'b0);
        check("sim1_spots", 64'(rob_spots), 64'd2);
        check("sim1_valid", 64'(rob_outputs_valid), 64'd3);
        check_model("sim1");
        drive(2, 1, 1'b1, 1'b0);
        check("sim2_spots", 64'(rob_spots), 64'd1);
        check("sim2_tail", 64'(rob_tail), 64'd2);
        check_model("sim2");

        // Down to count=5, then flush with concurrent dispatch/retire
        drive(0, 2, 1'b1, 1'b0);
        check("pre_fl_spots", 64'(rob_spots), 64'd3);
        drive(3, 2, 1'b1, 1'b1);
        check("fl_valid", 64'(rob_outputs_valid), 64'd0);
        check("fl_spots", 64'(rob_spots), 64'd3);
        check("fl_tail", 64'(rob_tail), 64'd0);

        // Walk head/tail to 6, then dispatch across the wrap
        drive(3, 0, 1'b1, 1'b0);
        drive(3, 3, 1'b1, 1'b0);
        drive(0, 3, 1'b1, 1'b0);
        check("w0_valid", 64'(rob_outputs_valid), 64'd0);
        check("w0_tail", 64'(rob_tail), 64'd6);
        drive(3, 0, 1'b1, 1'b0);
        check("wrap_tail", 64'(rob_tail), 64'd1);
        check("wrap_valid", 64'(rob_outputs_valid), 64'd3);
        check_model("wrap");
        drive(0, 3, 1'b1, 1'b0);
        check("wr_valid", 64'(rob_outputs_valid), 64'd0);
        check("wr_spots", 64'(rob_spots), 64'd3);
        drive(1, 0, 1'b1, 1'b0);
        check("w1_tail", 64'(rob_tail), 64'd2);
        check_model("w1");

        // Random legal traffic against the queue model
        for (int c = 0; c < 500; c++) begin
            mv = (q.size() < W) ? q.size() : W;
            ms = ((SZ - q.size()) < W) ? (SZ - q.size()) : W;
            nd = $urandom_range(ms, 0);
            nr = $urandom_range(mv, 0);
            drive(nd, nr, 1'b1, ($urandom_range(63, 0) == 0) ? 1'b1 : 1'b0);
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular N-wide reorder buffer feeding the retire stage.
- Accepts up to N in-order ROB_PACKETs per cycle from dispatch.
- Exposes the oldest up-to-N entries to retire as rob_outputs/rob_outputs_valid, and frees entries according to retire's num_retiring.
- Full flush on mispredict.

Parameters:
- ROB_SZ, default `ROB_SZ (32), number of entries; need not be a power of two.
- N, default `N (3), superscalar width for dispatch and retire.

Ports:
- clock  input  1  system clock, posedge.
- reset  input  1  synchronous, active-low (0 = reset).
- flush  input  1  mispredict flush; empties the ROB.
- rob_inputs  input  ROB_PACKET[N]  packets from dispatch, index 0 oldest.
- num_dispatched  input  NUM_SCALAR_BITS  count of valid rob_inputs, 0..N.
- rob_spots  output  NUM_SCALAR_BITS  entries dispatch may write this cycle, min(ROB_SZ-count, N).
- rob_tail  output  ROB_IDX_BITS  index that rob_inputs[0] will occupy; the tag for later instructions is rob_tail+i mod ROB_SZ.
- rob_outputs  output  ROB_PACKET[N]  entries head+0..head+N-1 mod ROB_SZ, index 0 oldest.
- rob_outputs_valid  output  NUM_SCALAR_BITS  min(count, N).
- num_retiring  input  NUM_SCALAR_BITS  entries retire consumes this cycle, 0..rob_outputs_valid.

Behaviour:
- State:
  - entries[ROB_SZ] of ROB_PACKET.
  - head, tail: ROB_IDX_BITS = $clog2(ROB_SZ).
  - count: $clog2(ROB_SZ+1) bits, range 0..ROB_SZ.
- Reset (reset==0 at posedge):
  - head=tail=count=0; all entries zeroed.
  - Outputs after reset: rob_outputs_valid=0, rob_spots=min(ROB_SZ,N), rob_tail=0, rob_outputs all zero.
- Outputs are combinational from registered state only.
  - No same-cycle bypass: retiring entries do not raise rob_spots until the next cycle.
  - Dispatched entries appear in rob_outputs the cycle after the write (1-cycle latency).
- Per posedge with reset==1 and flush==0:
  - entries[(tail+i) mod ROB_SZ] <= rob_inputs[i] for i < num_dispatched.
  - tail <= (tail+num_dispatched) mod ROB_SZ.
  - head <= (head+num_retiring) mod ROB_SZ.
  - count <= count + num_dispatched - num_retiring.
- Simultaneous dispatch and retire in one cycle is legal. Both pointers update independently.
  - At full, dispatch is still blocked that cycle (rob_spots was 0).
- Wrap-around:
  - Indices are computed with an explicit compare/subtract against ROB_SZ, not bit truncation, so non-power-of-two sizes work.
  - A group may straddle the wrap; e.g. ROB_SZ=8, tail=7, 3 dispatched writes slots 7, 0, 1.
- Empty: count==0 → rob_outputs_valid=0. rob_outputs contents are don't-care; retire must ignore them.
- Full: count==ROB_SZ → rob_spots=0.
- flush==1 at posedge:
  - head=tail=count=0; entry contents are retained and unused.
  - flush overrides dispatch and retire in the same cycle.
- reset is asserted over flush when both are active.
- Reset mid-operation: the next cycle behaves as if freshly reset.
- Illegal inputs: num_dispatched>rob_spots or num_retiring>rob_outputs_valid is undefined behaviour; the checks below flag it when enabled.

Optional Feature:
- Macro: ROB_DEBUG_EN.
- With it defined:
  - Adds output debug_count (count width), exposing count.
  - Adds immediate $error checks on each posedge for num_dispatched>rob_spots, num_retiring>rob_outputs_valid, num_dispatched>N and num_retiring>N.
  - Adds a check that count==((tail-head) mod ROB_SZ), or ROB_SZ when full.
- Without it: no extra port, no checks, identical functional behaviour.

Decomposition:
- Shared sys_defs package already carries ROB_PACKET, `N, `ROB_SZ and NUM_SCALAR_BITS.
- Add there:
  - ROB_IDX_BITS = $clog2(`ROB_SZ).
  - typedef ROB_IDX logic[ROB_IDX_BITS-1:0], used as the tag type elsewhere.
- Sub-module: rob_wrap_add, a combinational (index + small offset) mod ROB_SZ. It is instanced for head, tail and each of the N read/write slots.

Test Plan (ROB_SZ=8, N=3):
- Reset: hold reset=0 for 2 cycles → rob_outputs_valid=0, rob_spots=3, rob_tail=0. Release and dispatch 3 → next cycle rob_outputs_valid=3, rob_outputs[0..2] equal the inputs in order, rob_tail=3.
- Fill: dispatch 3,3,2 with no retire → rob_spots 3,3,2,0. count=8; further dispatch is blocked while rob_outputs_valid stays 3.
- Wrap: from head=6, tail=6, count=0, dispatch 3 → slots 6, 7, 0 written, rob_tail=1. Retire 3 next cycle → head=1, rob_outputs_valid=0.
- Simultaneous: count=8, dispatch 0 and retire 2 → rob_spots=0 in that cycle, 2 on the next. Then dispatch 2 with retire 1 in one cycle → count 6→7.
- Flush: count=5, flush=1 together with dispatch 3 and retire 2 → next cycle count=0, rob_outputs_valid=0, rob_spots=3, rob_tail=0.
- Random: 500 cycles of legal random dispatch/retire checked against a queue model for rob_outputs order and rob_spots. With ROB_DEBUG_EN, inject num_retiring>rob_outputs_valid → $error fires.
